// File: rtl/uart_cfg_ctrl_if.sv
// Frame stream from UART_processor into the config controller, and the forwarded data stream out of it.
interface uart_cfg_ctrl_if;
  logic [8:0] frame;
  logic       frame_valid;
  logic [8:0] data_out;
  logic       data_valid;
  logic       data_ready;

  modport slave  (input frame, frame_valid, data_ready, output data_out, data_valid);
  modport master (output frame, frame_valid, data_ready, input data_out, data_valid);
endinterface

// File: rtl/uart_cfg_ctrl.sv
// UART receive-path config controller: ESC command parser, idle-gated config apply, 2-entry data FIFO.
// Optional feature macro UART_CFG_ESC_TIMEOUT_EN: abandon an ESC with no command byte after ESC_TIMEOUT cycles.
module uart_cfg_ctrl #(
  parameter int unsigned IDLE_CYCLES = 64,
  parameter int unsigned ESC_TIMEOUT = 1024,
  parameter logic [7:0]  ESC_CODE    = 8'h1B
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           Rx,
  uart_cfg_ctrl_if.slave bus,
  output logic [2:0]     baud,
  output logic           baud_ready,
  output logic           parity,
  output logic           parity_type,
  output logic           stop_bits,
  output logic [3:0]     frame_length,
  output logic           cfg_pending,
  output logic           cmd_err,
  output logic           overflow
);

  typedef enum logic {PIDLE, PESC} parse_t;
  typedef enum logic [1:0] {CLEAN, PEND, APPLY0, APPLY1} apply_t;

  localparam logic [8:0]  ESC_FRAME = {1'b0, ESC_CODE};
  localparam int unsigned IW        = $clog2(IDLE_CYCLES + 1);

  parse_t        pstate;
  apply_t        astate;
  logic [IW-1:0] idle_cnt;

  logic [2:0] sh_baud;
  logic       sh_parity;
  logic       sh_ptype;
  logic       sh_stop;
  logic [3:0] sh_flen;

  logic [8:0] mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;

  logic is_esc;
  logic is_cmd;
  logic legal;
  logic cmd_accept;
  logic cmd_reject;
  logic push;
  logic push_ok;
  logic pop;
  logic esc_expired;

  // A frame seen in PESC that is not ESC is a command byte; legality follows its class in bits 7:6.
  always_comb begin
    is_esc = bus.frame == ESC_FRAME;
    is_cmd = bus.frame_valid && pstate == PESC && !is_esc;
    legal  = 1'b0;
    case (bus.frame[7:6])
      2'b01:   legal = bus.frame[2:0] <= 3'd5;
      2'b10:   legal = 1'b1;
      2'b11:   legal = bus.frame[3:0] >= 4'd5 && bus.frame[3:0] <= 4'd9;
      default: legal = 1'b0;
    endcase
    cmd_accept = is_cmd && legal;
    cmd_reject = is_cmd && !legal;
    push       = bus.frame_valid && ((pstate == PIDLE && !is_esc) || (pstate == PESC && is_esc));
    pop        = count != 2'd0 && bus.data_ready;
    push_ok    = push && (count != 2'd2 || pop);
  end

`ifdef UART_CFG_ESC_TIMEOUT_EN
  localparam int unsigned EW = $clog2(ESC_TIMEOUT + 1);
  logic [EW-1:0] esc_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      esc_cnt <= '0;
    else if (pstate != PESC || bus.frame_valid)
      esc_cnt <= '0;
    else
      esc_cnt <= esc_cnt + 1'b1;
  end

  assign esc_expired = pstate == PESC && !bus.frame_valid && esc_cnt == EW'(ESC_TIMEOUT - 1);
`else
  assign esc_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pstate    <= PIDLE;
      cmd_err   <= 1'b0;
      sh_baud   <= 3'b010;
      sh_parity <= 1'b1;
      sh_ptype  <= 1'b0;
      sh_stop   <= 1'b0;
      sh_flen   <= 4'd8;
    end else begin
      cmd_err <= cmd_reject || esc_expired;
      if (esc_expired)
        pstate <= PIDLE;
      else if (bus.frame_valid)
        pstate <= (pstate == PIDLE && is_esc) ? PESC : PIDLE;
      if (cmd_accept) begin
        case (bus.frame[7:6])
          2'b01: sh_baud <= bus.frame[2:0];
          2'b10: begin
            sh_parity <= bus.frame[0];
            sh_ptype  <= bus.frame[1];
            sh_stop   <= bus.frame[2];
          end
          2'b11:   sh_flen <= bus.frame[3:0];
          default: ;
        endcase
      end
    end
  end

  // Shadow is copied on the edge entering APPLY0; a command landing during APPLY0/APPLY1 keeps cfg_pending set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      astate       <= CLEAN;
      idle_cnt     <= '0;
      cfg_pending  <= 1'b0;
      baud_ready   <= 1'b0;
      baud         <= 3'b010;
      parity       <= 1'b1;
      parity_type  <= 1'b0;
      stop_bits    <= 1'b0;
      frame_length <= 4'd8;
    end else begin
      baud_ready <= 1'b1;
      if (cmd_accept)
        cfg_pending <= 1'b1;
      case (astate)
        CLEAN: begin
          idle_cnt <= '0;
          if (cfg_pending)
            astate <= PEND;
        end
        PEND: begin
          if (!Rx || bus.frame_valid)
            idle_cnt <= '0;
          else if (idle_cnt == IW'(IDLE_CYCLES - 1)) begin
            astate       <= APPLY0;
            baud         <= sh_baud;
            parity       <= sh_parity;
            parity_type  <= sh_ptype;
            stop_bits    <= sh_stop;
            frame_length <= sh_flen;
            baud_ready   <= 1'b0;
          end else
            idle_cnt <= idle_cnt + 1'b1;
        end
        APPLY0: begin
          astate   <= APPLY1;
          idle_cnt <= '0;
          if (!cmd_accept)
            cfg_pending <= 1'b0;
        end
        APPLY1: begin
          idle_cnt <= '0;
          astate   <= (cfg_pending || cmd_accept) ? PEND : CLEAN;
        end
        default: astate <= CLEAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= bus.frame;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      if (push && !push_ok)
        overflow <= 1'b1;
      count <= count + 2'(push_ok) - 2'(pop);
    end
  end

  assign bus.data_out   = mem[rd_ptr];
  assign bus.data_valid = count != 2'd0;

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Self-checking bench for uart_cfg_ctrl: randomized data stream and commands against a behavioural model.
module tb_uart_cfg_ctrl;

  localparam int         IDLE   = 64;
  localparam int         ESC_TO = 1024;
  localparam logic [8:0] ESC    = 9'h01B;

  typedef struct packed {
    logic [2:0] baud;
    logic       parity;
    logic       ptype;
    logic       stop;
    logic [3:0] flen;
  } cfg_t;

  localparam cfg_t RESET_CFG = '{baud: 3'd2, parity: 1'b1, ptype: 1'b0, stop: 1'b0, flen: 4'd8};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Rx  = 1'b1;
  logic [2:0] baud;
  logic       baud_ready;
  logic       parity;
  logic       parity_type;
  logic       stop_bits;
  logic [3:0] frame_length;
  logic       cfg_pending;
  logic       cmd_err;
  logic       overflow;

  int   tests = 0;
  int   fails = 0;
  cfg_t exp_active;
  cfg_t exp_shadow;
  cfg_t got;

  uart_cfg_ctrl_if bus();

  uart_cfg_ctrl #(.IDLE_CYCLES(IDLE), .ESC_TIMEOUT(ESC_TO), .ESC_CODE(8'h1B)) dut (
    .clk(clk), .rst(rst), .Rx(Rx), .bus(bus),
    .baud(baud), .baud_ready(baud_ready), .parity(parity), .parity_type(parity_type),
    .stop_bits(stop_bits), .frame_length(frame_length), .cfg_pending(cfg_pending),
    .cmd_err(cmd_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  assign got = {baud, parity, parity_type, stop_bits, frame_length};

  // Command semantics straight from the command table; illegal codes leave the config untouched.
  function automatic cfg_t cmd_apply(cfg_t s, logic [7:0] c);
    cfg_t n = s;
    if (c[7:6] == 2'b01 && c[2:0] < 3'd6) n.baud = c[2:0];
    else if (c[7:6] == 2'b10) begin
      n.parity = c[0];
      n.ptype  = c[1];
      n.stop   = c[2];
    end else if (c[7:6] == 2'b11 && c[3:0] >= 4'd5 && c[3:0] <= 4'd9) n.flen = c[3:0];
    return n;
  endfunction

  function automatic logic [8:0] rand_data();
    logic [8:0] f;
    do f = 9'($urandom); while (f == ESC);
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [8:0] f);
    bus.frame       = f;
    bus.frame_valid = 1'b1;
    step();
    bus.frame_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    bus.frame_valid = 1'b0;
    Rx              = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    exp_active = RESET_CFG;
    exp_shadow = RESET_CFG;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    tests++; if (got !== RESET_CFG) begin fails++; $display("[TB] FAIL reset_cfg: got %h want %h", got, RESET_CFG); end
    tests++; if (baud_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_baud_ready: got %b want 0", baud_ready); end
    tests++; if (cfg_pending !== 1'b0) begin fails++; $display("[TB] FAIL reset_pending: got %b want 0", cfg_pending); end
    tests++; if (cmd_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_cmd_err: got %b want 0", cmd_err); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
    tests++; if (bus.data_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_data_valid: got %b want 0", bus.data_valid); end
    tests++; if (bus.data_out !== 9'h000) begin fails++; $display("[TB] FAIL reset_data_out: got %h want 000", bus.data_out); end
    rst = 1'b1;
    #2;
    tests++; if (baud_ready !== 1'b0) begin fails++; $display("[TB] FAIL release_baud_ready_low: got %b want 0", baud_ready); end
    step();
    tests++; if (baud_ready !== 1'b1) begin fails++; $display("[TB] FAIL release_baud_ready_high: got %b want 1", baud_ready); end
    exp_active = RESET_CFG;
    exp_shadow = RESET_CFG;
  endtask

  task automatic test_data_stream();
    logic [8:0] q[$];
    logic       exp_ovf = 1'b0;
    logic [8:0] f;
    bit         v, r, popm;
    int         sz;
    Rx = 1'b1;
    bus.data_ready = 1'b1;
    send_frame(9'h041);
    tests++; if (bus.data_valid !== 1'b1 || bus.data_out !== 9'h041) begin fails++; $display("[TB] FAIL data_first: got %b/%h want 1/041", bus.data_valid, bus.data_out); end
    send_frame(9'h042);
    tests++; if (bus.data_valid !== 1'b1 || bus.data_out !== 9'h042) begin fails++; $display("[TB] FAIL data_second: got %b/%h want 1/042", bus.data_valid, bus.data_out); end
    step();
    tests++; if (bus.data_valid !== 1'b0) begin fails++; $display("[TB] FAIL data_drained: got %b want 0", bus.data_valid); end
    for (int i = 0; i < 120; i++) begin
      v = ($urandom % 4) != 0;
      r = ($urandom % 3) != 0;
      f = rand_data();
      bus.frame       = f;
      bus.frame_valid = v;
      bus.data_ready  = r;
      sz   = q.size();
      popm = r && sz > 0;
      if (popm) void'(q.pop_front());
      if (v) begin
        if (sz < 2 || popm) q.push_back(f);
        else exp_ovf = 1'b1;
      end
      step();
      tests++; if (bus.data_valid !== (q.size() != 0)) begin fails++; $display("[TB] FAIL stream_valid[%0d]: got %b want %b", i, bus.data_valid, q.size() != 0); end
      if (q.size() != 0) begin
        tests++; if (bus.data_out !== q[0]) begin fails++; $display("[TB] FAIL stream_data[%0d]: got %h want %h", i, bus.data_out, q[0]); end
      end
      tests++; if (overflow !== exp_ovf) begin fails++; $display("[TB] FAIL stream_overflow[%0d]: got %b want %b", i, overflow, exp_ovf); end
    end
    bus.frame_valid = 1'b0;
    bus.data_ready  = 1'b1;
    repeat (3) step();
    tests++; if (bus.data_valid !== 1'b0) begin fails++; $display("[TB] FAIL stream_flush: got %b want 0", bus.data_valid); end
    tests++; if (got !== exp_active || cfg_pending !== 1'b0) begin fails++; $display("[TB] FAIL stream_cfg: got %h/%b want %h/0", got, cfg_pending, exp_active); end
  endtask

  task automatic run_config(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2, input int n);
    logic [7:0] cmds[3];
    cmds = '{c0, c1, c2};
    Rx = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_frame(ESC);
      send_frame({1'b0, cmds[i]});
      exp_shadow = cmd_apply(exp_shadow, cmds[i]);
      tests++; if (cfg_pending !== 1'b1 || cmd_err !== 1'b0) begin fails++; $display("[TB] FAIL cmd_accept[%0d]: pending/err got %b/%b want 1/0", i, cfg_pending, cmd_err); end
    end
    for (int i = 0; i < 100; i++) begin
      Rx = (i % 8 == 0 || i == 99) ? 1'b0 : 1'($urandom);
      step();
      tests++; if (got !== exp_active || cfg_pending !== 1'b1) begin fails++; $display("[TB] FAIL busy_hold[%0d]: got %h/%b want %h/1", i, got, cfg_pending, exp_active); end
    end
    Rx = 1'b1;
    for (int k = 1; k <= IDLE + 1; k++) begin
      step();
      if (k < IDLE) begin
        tests++; if (got !== exp_active || baud_ready !== 1'b1) begin fails++; $display("[TB] FAIL idle_hold[%0d]: got %h/%b want %h/1", k, got, baud_ready, exp_active); end
      end else if (k == IDLE) begin
        tests++; if (got !== exp_shadow || baud_ready !== 1'b0 || cfg_pending !== 1'b1) begin fails++; $display("[TB] FAIL apply_edge: got %h/%b/%b want %h/0/1", got, baud_ready, cfg_pending, exp_shadow); end
      end else begin
        tests++; if (got !== exp_shadow || baud_ready !== 1'b1 || cfg_pending !== 1'b0) begin fails++; $display("[TB] FAIL apply_done: got %h/%b/%b want %h/1/0", got, baud_ready, cfg_pending, exp_shadow); end
      end
    end
    exp_active = exp_shadow;
  endtask

  task automatic test_config();
    bus.data_ready = 1'b1;
    run_config(8'h44, 8'h00, 8'h00, 1);
    tests++; if (baud !== 3'd4) begin fails++; $display("[TB] FAIL baud_is_4: got %0d want 4", baud); end
    run_config({5'b01000, 3'($urandom_range(0, 5))}, {5'b10000, 3'($urandom)},
               {4'b1100, 4'($urandom_range(5, 9))}, 3);
  endtask

  task automatic test_cmd_reject();
    logic [7:0] c;
    logic [3:0] bad;
    Rx = 1'b1;
    bus.data_ready = 1'b1;
    send_frame(ESC);
    send_frame(9'h0CC);
    tests++; if (cmd_err !== 1'b1 || cfg_pending !== 1'b0) begin fails++; $display("[TB] FAIL reject_cc: err/pending got %b/%b want 1/0", cmd_err, cfg_pending); end
    step();
    tests++; if (cmd_err !== 1'b0) begin fails++; $display("[TB] FAIL reject_pulse_width: got %b want 0", cmd_err); end
    for (int i = 0; i < 9; i++) begin
      case (i % 3)
        0: c = {2'b00, 6'($urandom)};
        1: c = {2'b01, 3'($urandom), 2'b11, 1'($urandom)};
        default: begin
          do bad = 4'($urandom); while (bad >= 4'd5 && bad <= 4'd9);
          c = {2'b11, 2'($urandom), bad};
        end
      endcase
      send_frame(ESC);
      send_frame({1'b0, c});
      tests++; if (cmd_err !== 1'b1 || cfg_pending !== 1'b0) begin fails++; $display("[TB] FAIL reject_rand[%0d] cmd %h: err/pending got %b/%b want 1/0", i, c, cmd_err, cfg_pending); end
    end
    repeat (IDLE + 5) step();
    tests++; if (got !== exp_active) begin fails++; $display("[TB] FAIL reject_no_change: got %h want %h", got, exp_active); end
    send_frame(ESC);
    tests++; if (bus.data_valid !== 1'b0) begin fails++; $display("[TB] FAIL esc_not_forwarded: got %b want 0", bus.data_valid); end
    send_frame(ESC);
    tests++; if (bus.data_valid !== 1'b1 || bus.data_out !== ESC) begin fails++; $display("[TB] FAIL esc_literal: got %b/%h want 1/01b", bus.data_valid, bus.data_out); end
    send_frame(9'h0AA);
    tests++; if (bus.data_valid !== 1'b1 || bus.data_out !== 9'h0AA) begin fails++; $display("[TB] FAIL after_literal: got %b/%h want 1/0aa", bus.data_valid, bus.data_out); end
    step();
    run_config({5'b10000, 3'($urandom)}, 8'h00, 8'h00, 1);
  endtask

  task automatic test_esc_timeout();
    int first = 0;
    int pulses = 0;
    Rx = 1'b1;
    bus.data_ready = 1'b1;
    send_frame(ESC);
    for (int k = 1; k <= ESC_TO + 20; k++) begin
      step();
      if (cmd_err === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    send_frame(9'h045);
`ifdef UART_CFG_ESC_TIMEOUT_EN
    tests++; if (pulses != 1 || first != ESC_TO) begin fails++; $display("[TB] FAIL esc_timeout: pulses %0d at %0d want 1 at %0d", pulses, first, ESC_TO); end
    tests++; if (bus.data_valid !== 1'b1 || bus.data_out !== 9'h045 || cfg_pending !== 1'b0) begin fails++; $display("[TB] FAIL post_timeout_data: got %b/%h/%b want 1/045/0", bus.data_valid, bus.data_out, cfg_pending); end
`else
    tests++; if (pulses != 0) begin fails++; $display("[TB] FAIL esc_wait: got %0d pulses want 0", pulses); end
    tests++; if (bus.data_valid !== 1'b0 || cfg_pending !== 1'b1) begin fails++; $display("[TB] FAIL esc_wait_cmd: got %b/%b want 0/1", bus.data_valid, cfg_pending); end
    exp_shadow = cmd_apply(exp_shadow, 8'h45);
`endif
  endtask

  task automatic test_overflow_reset();
    logic [8:0] f0, f1, f2;
    do_reset();
    f0 = rand_data();
    f1 = rand_data();
    f2 = rand_data();
    bus.data_ready = 1'b0;
    send_frame(f0);
    send_frame(f1);
    tests++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL ovf_early: got %b want 0", overflow); end
    send_frame(f2);
    tests++; if (overflow !== 1'b1 || bus.data_valid !== 1'b1 || bus.data_out !== f0) begin fails++; $display("[TB] FAIL ovf_full: got %b/%b/%h want 1/1/%h", overflow, bus.data_valid, bus.data_out, f0); end
    bus.data_ready = 1'b1;
    step();
    tests++; if (bus.data_valid !== 1'b1 || bus.data_out !== f1) begin fails++; $display("[TB] FAIL ovf_second: got %b/%h want 1/%h", bus.data_valid, bus.data_out, f1); end
    step();
    tests++; if (bus.data_valid !== 1'b0 || overflow !== 1'b1) begin fails++; $display("[TB] FAIL ovf_third_dropped: got %b/%b want 0/1", bus.data_valid, overflow); end
    bus.data_ready = 1'b0;
    send_frame(9'h033);
    Rx = 1'b0;
    send_frame(ESC);
    send_frame(9'h045);
    repeat (10) begin
      Rx = ~Rx;
      step();
    end
    tests++; if (cfg_pending !== 1'b1) begin fails++; $display("[TB] FAIL mid_pend: got %b want 1", cfg_pending); end
    #2 rst = 1'b0;
    #1;
    tests++; if (got !== RESET_CFG || cfg_pending !== 1'b0 || baud_ready !== 1'b0) begin fails++; $display("[TB] FAIL midreset_cfg: got %h/%b/%b want %h/0/0", got, cfg_pending, baud_ready, RESET_CFG); end
    tests++; if (overflow !== 1'b0 || bus.data_valid !== 1'b0 || bus.data_out !== 9'h000) begin fails++; $display("[TB] FAIL midreset_fifo: got %b/%b/%h want 0/0/000", overflow, bus.data_valid, bus.data_out); end
    step();
    rst = 1'b1;
    Rx  = 1'b1;
    repeat (IDLE + 10) step();
    tests++; if (got !== RESET_CFG || cfg_pending !== 1'b0 || baud_ready !== 1'b1) begin fails++; $display("[TB] FAIL pending_lost: got %h/%b/%b want %h/0/1", got, cfg_pending, baud_ready, RESET_CFG); end
  endtask

  initial begin
    bus.frame       = 9'h000;
    bus.frame_valid = 1'b0;
    bus.data_ready  = 1'b1;
    exp_active      = RESET_CFG;
    exp_shadow      = RESET_CFG;
    test_reset();
    test_data_stream();
    test_config();
    test_cmd_reject();
    test_esc_timeout();
    test_overflow_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
